// File: rtl/shift_add_mul_ctrl_pkg.sv
// Shared FPU definitions: the state encoding for the multiply controller and the
// default mantissa width.
package shift_add_mul_ctrl_pkg;

    localparam int DEFAULT_MANT_W = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_t;

    // IDLE and DONE are the only states in which a new request may be taken.
    function automatic logic is_ready_state(input state_t s);
        return (s == S_IDLE) || (s == S_DONE);
    endfunction

endpackage

// File: rtl/shift_add_mul_ctrl_pp_row.sv
// One partial-product row: the multiplicand gated by a single multiplier bit.
// Purely combinational; reused every iteration by the multiply controller.
module pp_row #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic             b,
    output logic [WIDTH-1:0] c
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign c[gi] = a[gi] & b;
        end
    endgenerate

endmodule

// File: rtl/shift_add_mul_ctrl.sv
// Iterative radix-2 unsigned shift-add multiplier with a start/done handshake.
// One row is accumulated and the {acc_hi,acc_lo} pair shifted right each RUN cycle.
module shift_add_mul_ctrl
    import shift_add_mul_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_MANT_W,
    parameter int CNT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    state_t               r_state;
    logic                 r_ready;
    logic                 r_busy;
    logic                 r_done;

    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [WIDTH-1:0]     r_acc_hi;
    logic [WIDTH-1:0]     r_acc_lo;
    logic [CNT_W-1:0]     r_cnt;
    logic [2*WIDTH-1:0]   r_product;

    logic [WIDTH-1:0]     w_pp;
    logic [WIDTH:0]       w_sum;
    logic [WIDTH-1:0]     w_acc_hi_next;
    logic [WIDTH-1:0]     w_acc_lo_next;
    logic                 w_accept;
    logic                 w_zero;
    logic                 w_last;

    pp_row #(
        .WIDTH (WIDTH)
    ) u_pp_row (
        .a (r_a),
        .b (r_b[0]),
        .c (w_pp)
    );

    // The extra sum bit keeps the carry; it becomes the MSB of acc_hi after the shift.
    assign w_sum         = {1'b0, r_acc_hi} + {1'b0, w_pp};
    assign w_acc_hi_next = w_sum[WIDTH:1];
    assign w_acc_lo_next = {w_sum[0], r_acc_lo[WIDTH-1:1]};

    assign w_accept = start && is_ready_state(r_state);
    assign w_zero   = (a == '0) || (b == '0);
    assign w_last   = (r_state == S_RUN) && (r_cnt == CNT_W'(WIDTH - 1));

    // Control FSM; handshake outputs are registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept && w_zero) begin
                        r_state <= S_DONE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (w_accept) begin
                        r_state <= S_RUN;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end else begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (w_last) begin
                        r_state <= S_DONE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= S_RUN;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Datapath: operand latch, accumulator shift and product capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a       <= '0;
            r_b       <= '0;
            r_acc_hi  <= '0;
            r_acc_lo  <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else if (w_accept) begin
            r_a      <= a;
            r_b      <= b;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_cnt    <= '0;
            if (w_zero) begin
                r_product <= '0;
            end
        end else if (r_state == S_RUN) begin
            r_acc_hi <= w_acc_hi_next;
            r_acc_lo <= w_acc_lo_next;
            r_b      <= r_b >> 1;
            r_cnt    <= r_cnt + CNT_W'(1);
            // Capture the post-step accumulator so the final row is included.
            if (w_last) begin
                r_product <= {w_acc_hi_next, w_acc_lo_next};
            end
        end
    end

    assign ready   = r_ready;
    assign busy    = r_busy;
    assign done    = r_done;
    assign product = r_product;

endmodule

// File: tb/tb_shift_add_mul_ctrl.sv
// Scoreboard bench for the shift-add multiplier: stimulus pushes a*b on each
// accepted start, a negedge monitor pops and compares on every done pulse.
module tb_shift_add_mul_ctrl;

    localparam int W = 8;
    localparam int RAND_OPS = 3000;

    logic           clk;
    logic           rst;
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           ready;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int n_checks = 0;
    int n_fail   = 0;
    int n_ops    = 0;

    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] held_prod;
    logic [2*W-1:0] mon_exp;

    shift_add_mul_ctrl #(
        .WIDTH (W),
        .CNT_W (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: product must only change on a done pulse, and each done must match the model.
    initial begin
        held_prod = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                held_prod = '0;
            end else if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("product", 32'(product), 32'(mon_exp));
                    held_prod = mon_exp;
                    n_ops++;
                    $display("op %0d: product=0x%04h expected=0x%04h", n_ops, product, mon_exp);
                end
            end else begin
                check("product_hold", 32'(product), 32'(held_prod));
            end
        end
    end

    // Called at #1 after a posedge; returns at #1 after the accepting edge.
    task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tbv);
        logic zero;
        zero = (ta == 0) || (tbv == 0);
        check("ready_before_start", 32'(ready), 32'd1);
        start = 1'b1;
        a = ta;
        b = tbv;
        @(posedge clk);
        #1;
        exp_q.push_back(16'(ta) * 16'(tbv));
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        check("busy_after_accept", 32'(busy), zero ? 32'd0 : 32'd1);
    endtask

    // Counts edges after the accepting edge until done is visible.
    task automatic wait_done(input int exp_lat, input string name);
        int n;
        n = 0;
        while (!done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, 32'(n), 32'(exp_lat));
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ta;
        logic [W-1:0] tbv;
        int           gap;
        int           n;

        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_product", 32'(product), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        start_op(8'hFF, 8'hFF);
        wait_done(W, "max_latency");
        @(posedge clk);
        #1;
        check("done_one_cycle", 32'(done), 32'd0);

        start_op(8'h00, 8'h5A);
        wait_done(0, "zero_a_latency");
        @(posedge clk);
        #1;
        start_op(8'h37, 8'h00);
        wait_done(0, "zero_b_latency");
        @(posedge clk);
        #1;

        // Request held during RUN must be ignored; a request on the done cycle is taken.
        start_op(8'h0D, 8'h0B);
        start = 1'b1;
        a = 8'hFF;
        b = 8'h01;
        n = 0;
        while (!done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("ignored_start_latency", 32'(n), 32'(W));
        a = 8'h80;
        b = 8'h02;
        @(posedge clk);
        #1;
        exp_q.push_back(16'h0100);
        start = 1'b0;
        check("b2b_busy", 32'(busy), 32'd1);
        wait_done(W, "b2b_latency");
        @(posedge clk);
        #1;

        // Reset during RUN aborts with no done pulse.
        start_op(8'hAA, 8'h55);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_product", 32'(product), 32'd0);
        repeat (12) @(posedge clk);
        #1;
        start_op(8'hAA, 8'h55);
        wait_done(W, "after_abort_latency");

        for (int i = 0; i < RAND_OPS; i++) begin
            ta  = W'($urandom);
            tbv = W'($urandom);
            if ($urandom_range(15) == 0) ta = '0;
            if ($urandom_range(15) == 0) tbv = '0;
            start_op(ta, tbv);
            wait_done(((ta == 0) || (tbv == 0)) ? 0 : W, "rand_latency");
            gap = $urandom_range(3);
            if (gap > 0) begin
                @(posedge clk);
                #1;
                check("rand_done_one_cycle", 32'(done), 32'd0);
                for (int k = 1; k < gap; k++) begin
                    @(posedge clk);
                    #1;
                end
            end
        end

        repeat (3) @(posedge clk);
        #1;
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
